// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - Multicycle RV32M MUL controller driving the shared ALU with shift-and-add steps.
// Multiplier bits are consumed LSB-first; optional early exit once the remaining multiplier is zero.
module mul_seq_ctrl #(
  parameter int EARLY_EXIT = 1,
  parameter int N_ITER     = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [5:0] ITER_MAX = 6'(N_ITER);
  localparam bit         EE = (EARLY_EXIT != 0);

  state_t      state;
  logic [31:0] acc;
  logic [31:0] mc;
  logic [31:0] mp;
  logic [5:0]  iter;

  // Outputs are registered alongside the next state, so each takes the value
  // of the state being entered; ALU operands are stable for the whole step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      acc     <= 32'h0;
      mc      <= 32'h0;
      mp      <= 32'h0;
      iter    <= 6'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 32'h0;
      alu_a   <= 32'h0;
      alu_b   <= 32'h0;
      alu_op  <= OP_ADD;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= 32'h0;
            mc    <= multiplicand;
            mp    <= multiplier;
            iter  <= 6'd0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (iter == ITER_MAX || (EE && mp == 32'h0)) begin
            product <= acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (mp[0]) begin
            alu_a  <= acc;
            alu_b  <= mc;
            alu_op <= OP_ADD;
            state  <= S_ADD;
          end else begin
            alu_a  <= mc;
            alu_b  <= 32'h1;
            alu_op <= OP_SHL;
            state  <= S_SHIFT;
          end
        end
        S_ADD: begin
          acc    <= alu_result;
          alu_a  <= mc;
          alu_b  <= 32'h1;
          alu_op <= OP_SHL;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          mc     <= alu_result;
          mp     <= mp >> 1;
          iter   <= iter + 6'd1;
          alu_a  <= 32'h0;
          alu_b  <= 32'h0;
          alu_op <= OP_ADD;
          state  <= S_CHECK;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          alu_a  <= 32'h0;
          alu_b  <= 32'h0;
          alu_op <= OP_ADD;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - Scoreboard bench for mul_seq_ctrl, early-exit and full-iteration instances.
module tb_mul_seq_ctrl;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          shifts;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = 32'h0;
  logic [31:0] multiplier = 32'h0;

  logic        busy0, done0, busy1, done1;
  logic [31:0] product0, alu_a0, alu_b0, alu_result0;
  logic [31:0] product1, alu_a1, alu_b1, alu_result1;
  logic [3:0]  alu_op0, alu_op1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int          cnt_busy[2];
  int          cnt_shift[2];
  logic [31:0] prev_prod[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (op == 4'b0000) return a + b;
    if (op == 4'b0011) return a << b[4:0];
    return 32'h0;
  endfunction

  assign alu_result0 = alu(alu_a0, alu_b0, alu_op0);
  assign alu_result1 = alu(alu_a1, alu_b1, alu_op1);

  mul_seq_ctrl #(.EARLY_EXIT(1), .N_ITER(32)) dut_e (
    .clk(clk), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy0), .done(done0), .product(product0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_result(alu_result0)
  );

  mul_seq_ctrl #(.EARLY_EXIT(0), .N_ITER(32)) dut_f (
    .clk(clk), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy1), .done(done1), .product(product1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1)
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s dut%0d cyc=%0d actual=0x%08h required=0x%08h", name, k, cyc, act, exp);
    end
  endtask

  // Reference: product is plain modular multiply; timing follows the iteration/popcount rule.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit ee, input int t0);
    exp_t e;
    int n = 32;
    int p = 0;
    if (ee) begin
      n = 0;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    end
    for (int i = 0; i < n; i++) if (b[i]) p = p + 1;
    e.prod = a * b;
    e.lat = 2 + 2 * n + p;
    e.shifts = n;
    e.t0 = t0;
    return e;
  endfunction

  task automatic mon(input int k, input logic busy, input logic done, input logic [31:0] product,
                     input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    if (!reset_n) begin
      chk("reset_outputs", k, {31'h0, busy | done} | product | a | b | {28'h0, op}, 32'h0);
      cnt_busy[k] = 0;
      cnt_shift[k] = 0;
      prev_prod[k] = 32'h0;
      return;
    end
    if (busy) cnt_busy[k] = cnt_busy[k] + 1;
    if (op == 4'b0011) cnt_shift[k] = cnt_shift[k] + 1;
    if (op != 4'b0000 && op != 4'b0011) chk("alu_op_legal", k, {28'h0, op}, 32'h0);
    if (!busy) chk("alu_idle", k, a | b | {28'h0, op}, 32'h0);
    if (busy && done) chk("busy_done_excl", k, 32'h1, 32'h0);
    if (!done && product !== prev_prod[k]) chk("product_stable", k, product, prev_prod[k]);
    if (done) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        chk("unexpected_done", k, 32'h1, 32'h0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("product", k, product, e.prod);
        chk("latency", k, cyc - e.t0, e.lat);
        chk("busy_cycles", k, cnt_busy[k], e.lat - 1);
        chk("shift_ops", k, cnt_shift[k], e.shifts);
      end
      cnt_busy[k] = 0;
      cnt_shift[k] = 0;
    end
    prev_prod[k] = product;
  endtask

  always @(negedge clk) begin
    mon(0, busy0, done0, product0, alu_a0, alu_b0, alu_op0);
    mon(1, busy1, done1, product1, alu_a1, alu_b1, alu_op1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int t0);
    step();
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    t0 = cyc;
    q0.push_back(model(a, b, 1'b1, t0));
    q1.push_back(model(a, b, 1'b0, t0));
    step();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      step();
      n = n + 1;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("done_timeout", 0, q0.size() + q1.size(), 32'h0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic pulse_junk();
    start = 1'b1;
    multiplicand = $urandom;
    multiplier = $urandom | 32'h1;
    step();
    start = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    int t0;
    issue(a, b, t0);
    drain();
  endtask

  initial begin
    int t0;
    logic [31:0] a, b;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    run(32'd6, 32'd7);
    run(32'h1234, 32'h0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'h0001_0000, 32'h0001_0000);
    run(32'd5, 32'd2);
    run(32'h8000_0001, 32'h8000_0000);

    // Stray starts while busy (cycle 3) and in the early-exit DONE cycle (11).
    issue(32'd6, 32'd7, t0);
    go_to(t0 + 3);
    pulse_junk();
    go_to(t0 + 11);
    pulse_junk();
    drain();

    // Reset in cycle 4 aborts both instances; no DONE may follow.
    issue(32'd6, 32'd7, t0);
    go_to(t0 + 4);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    run(32'd9, 32'd9);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = b >> $urandom_range(0, 31);
        1: b = 32'h0;
        2: b = 32'h1 << $urandom_range(0, 31);
        default: ;
      endcase
      run(a, b);
    end

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
